// File: rtl/counter_nr_pkg.sv
// -----------------------------------------------------------------------------
// counter_nr_pkg
// Shared definitions for the non-recycling (saturating) counter family used in
// the microwave controller datapath.
//
// Contents:
//   CNR_DEFAULT_WIDTH - default counter width in bits
//   CNR_MAX_WIDTH     - widest counter the helper functions support
//   cnr_sat_next()    - saturating next-value: cur < max ? cur + 1 : max
//   cnr_clamp()       - min(val, max), used when a value is loaded from outside
//
// Both helpers work on CNR_MAX_WIDTH-bit operands so that any counter of
// width 2..16 can share them; callers zero-extend their operands.
// -----------------------------------------------------------------------------
package counter_nr_pkg;

    localparam int CNR_DEFAULT_WIDTH = 32'sd4;
    localparam int CNR_MAX_WIDTH     = 32'sd16;

    // Saturating increment. The compare happens before the add, and the add is
    // one bit wider than the operands, so cur == 16'hFFFF can never wrap.
    function automatic logic [15:0] cnr_sat_next(
        input logic [15:0] cur,
        input logic [15:0] max_val
    );
        logic [16:0] sum_s;
        sum_s = {1'b0, cur} + 17'd1;
        if (cur >= max_val) begin
            cnr_sat_next = max_val;
        end else begin
            cnr_sat_next = sum_s[15:0];
        end
    endfunction

    // Clamp an externally supplied value to the terminal count.
    function automatic logic [15:0] cnr_clamp(
        input logic [15:0] val,
        input logic [15:0] max_val
    );
        if (val > max_val) begin
            cnr_clamp = max_val;
        end else begin
            cnr_clamp = val;
        end
    endfunction

endpackage

// File: rtl/counter_nr_sat_inc.sv
// -----------------------------------------------------------------------------
// counter_nr_sat_inc
// Combinational saturating incrementer for counter_non_recycling.
//
// Parameters:
//   WIDTH     - operand width in bits (2..16)
//   MAX_COUNT - terminal value; the increment stops here
//
// Ports:
//   cur     in  [WIDTH-1:0]  current count (from the counter register)
//   en      in  1            increment request
//   next    out [WIDTH-1:0]  cur + 1 when en and below MAX_COUNT, else cur
//   at_max  out 1            cur == MAX_COUNT
// -----------------------------------------------------------------------------
module counter_nr_sat_inc
    import counter_nr_pkg::*;
#(
    parameter int WIDTH     = CNR_DEFAULT_WIDTH,
    parameter int MAX_COUNT = (32'sd1 <<< WIDTH) - 32'sd1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             en,
    output logic [WIDTH-1:0] next,
    output logic             at_max
);

    localparam logic [15:0]      MAX_WIDE = 16'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);

    logic [15:0] w_cur_wide;
    logic [15:0] w_next_wide;

    assign w_cur_wide = 16'(cur);

    // Select between the saturated increment and a plain hold.
    always_comb begin
        w_next_wide = 16'd0;
        if (en) begin
            w_next_wide = cnr_sat_next(w_cur_wide, MAX_WIDE);
        end else begin
            w_next_wide = w_cur_wide;
        end
    end

    assign next   = w_next_wide[WIDTH-1:0];
    assign at_max = (cur == MAX_W);

endmodule

// File: rtl/counter_non_recycling.sv
// -----------------------------------------------------------------------------
// counter_non_recycling
// Up-counter that saturates at MAX_COUNT instead of wrapping. Once at the
// terminal value it stays there until reset (or a load, when built with
// COUNTER_NR_LOAD_EN). Used as a one-shot elapsed-tick / sequence-step counter.
//
// Build option:
//   COUNTER_NR_LOAD_EN - adds load / load_value ports. A load on a rising edge
//                        takes min(load_value, MAX_COUNT) and beats en.
//
// Parameters:
//   WIDTH       - counter width in bits (2..16)
//   MAX_COUNT   - terminal value, 1 .. 2**WIDTH-1
//   RESET_VALUE - value forced while reset is low, <= MAX_COUNT
//
// Ports:
//   clock       in  1            rising-edge clock
//   reset       in  1            asynchronous active-low reset
//   en          in  1            count enable
//   load        in  1            (COUNTER_NR_LOAD_EN only) synchronous load
//   load_value  in  [WIDTH-1:0]  (COUNTER_NR_LOAD_EN only) value to load
//   data        out [WIDTH-1:0]  current count (register output)
//   at_max      out 1            data == MAX_COUNT, decoded from the register
// -----------------------------------------------------------------------------
module counter_non_recycling
    import counter_nr_pkg::*;
#(
    parameter int WIDTH       = CNR_DEFAULT_WIDTH,
    parameter int MAX_COUNT   = (32'sd1 <<< WIDTH) - 32'sd1,
    parameter int RESET_VALUE = 32'sd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
`ifdef COUNTER_NR_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] data,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] RESET_W  = WIDTH'(RESET_VALUE);
    localparam logic [15:0]      MAX_WIDE = 16'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_inc_next;
    logic             w_at_max;
    logic [WIDTH-1:0] w_d;

    counter_nr_sat_inc #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_sat_inc (
        .cur    (r_count),
        .en     (en),
        .next   (w_inc_next),
        .at_max (w_at_max)
    );

    // Next-state select: optional clamped load has priority over counting.
    always_comb begin
        w_d = r_count;
`ifdef COUNTER_NR_LOAD_EN
        if (load) begin
            w_d = WIDTH'(cnr_clamp(16'(load_value), MAX_WIDE));
        end else begin
            w_d = w_inc_next;
        end
`else
        w_d = w_inc_next;
`endif
    end

    // Count register; reset clears asynchronously, release acts on the next edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_W;
        end else begin
            r_count <= w_d;
        end
    end

    assign data   = r_count;
    assign at_max = w_at_max;

endmodule

// File: tb/tb_counter_non_recycling.sv
// -----------------------------------------------------------------------------
// tb_counter_non_recycling
// Scoreboard bench for counter_non_recycling. Two instances share the clock:
//   dut_a - default WIDTH=4, MAX_COUNT=15
//   dut_b - WIDTH=4, MAX_COUNT=9
// Stimulus is driven just after a falling edge and pushes the value expected
// after the following rising edge; the monitor pops and compares on the next
// falling edge. Asynchronous-reset effects are compared directly, between edges.
// Build with COUNTER_NR_LOAD_EN to also exercise the load path.
// -----------------------------------------------------------------------------
module tb_counter_non_recycling;
    import counter_nr_pkg::*;

    localparam int W = CNR_DEFAULT_WIDTH;

    logic         clock = 1'b0;
    logic         rst_a, en_a, rst_b, en_b;
    logic [W-1:0] data_a, data_b;
    logic         max_a, max_b;
`ifdef COUNTER_NR_LOAD_EN
    logic         ld_a, ld_b;
    logic [W-1:0] lv_a, lv_b;
`endif

    always #3 clock = ~clock;

    counter_non_recycling #(.WIDTH(W)) dut_a (
        .clock      (clock),
        .reset      (rst_a),
        .en         (en_a),
`ifdef COUNTER_NR_LOAD_EN
        .load       (ld_a),
        .load_value (lv_a),
`endif
        .data       (data_a),
        .at_max     (max_a)
    );

    counter_non_recycling #(.WIDTH(W), .MAX_COUNT(9)) dut_b (
        .clock      (clock),
        .reset      (rst_b),
        .en         (en_b),
`ifdef COUNTER_NR_LOAD_EN
        .load       (ld_b),
        .load_value (lv_b),
`endif
        .data       (data_b),
        .at_max     (max_b)
    );

    typedef struct {
        bit          which;
        int unsigned exp_data;
        bit          exp_max;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void expect_a(input int unsigned v, input bit m, input string name);
        exp_t e;
        e.which = 1'b0; e.exp_data = v; e.exp_max = m; e.name = name;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_b(input int unsigned v, input bit m, input string name);
        exp_t e;
        e.which = 1'b1; e.exp_data = v; e.exp_max = m; e.name = name;
        exp_q.push_back(e);
    endfunction

    // Monitor: everything queued during the previous cycle is due now.
    always @(negedge clock) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.which) begin
                check({e.name, "_data"}, 32'(data_b), e.exp_data);
                check({e.name, "_max"},  32'(max_b),  32'(e.exp_max));
            end else begin
                check({e.name, "_data"}, 32'(data_a), e.exp_data);
                check({e.name, "_max"},  32'(max_a),  32'(e.exp_max));
            end
        end
    end

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
`ifdef COUNTER_NR_LOAD_EN
        ld_a = 1'b0; ld_b = 1'b0; lv_a = '0; lv_b = '0;
`endif
        // Reset held low for 7 time units with the clock running.
        #1;
        check("rst_t1_data", 32'(data_a), 32'd0);
        check("rst_t1_max",  32'(max_a),  32'd0);
        check("rst_t1_b_data", 32'(data_b), 32'd0);
        #3;
        check("rst_t4_data", 32'(data_a), 32'd0);
        check("rst_t4_max",  32'(max_a),  32'd0);
        #3;
        // t=7: release and count 1, 2, 3.
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1;
        expect_a(1, 1'b0, "post_rst1");
        next_cycle(); expect_a(2, 1'b0, "post_rst2");
        next_cycle(); expect_a(3, 1'b0, "post_rst3");

        // Saturation: 20 enabled edges from 0.
        next_cycle();
        rst_a = 1'b0;
        #1;
        check("sat_clr_data", 32'(data_a), 32'd0);
        rst_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) next_cycle();
            expect_a((i < 15) ? i : 15, (i >= 15), $sformatf("sat_e%0d", i));
        end
        next_cycle(); en_a = 1'b0; expect_a(15, 1'b1, "sat_hold_en0");

        // Async reset mid-count at 5.
        next_cycle();
        rst_a = 1'b0; en_a = 1'b1;
        #1 rst_a = 1'b1;
        expect_a(1, 1'b0, "mid_c1");
        for (int i = 2; i <= 5; i++) begin
            next_cycle(); expect_a(i, 1'b0, $sformatf("mid_c%0d", i));
        end
        next_cycle();
        rst_a = 1'b0;
        #1;
        check("mid_async_data", 32'(data_a), 32'd0);
        check("mid_async_max",  32'(max_a),  32'd0);
        rst_a = 1'b1;
        expect_a(1, 1'b0, "mid_r1");
        next_cycle(); expect_a(2, 1'b0, "mid_r2");

        // Enable gating 1,0,1,0 from 0.
        next_cycle();
        rst_a = 1'b0;
        #1 rst_a = 1'b1;
        expect_a(1, 1'b0, "gate1");
        next_cycle(); en_a = 1'b0; expect_a(1, 1'b0, "gate2");
        next_cycle(); en_a = 1'b1; expect_a(2, 1'b0, "gate3");
        next_cycle(); en_a = 1'b0; expect_a(2, 1'b0, "gate4");

        // MAX_COUNT = 9 instance.
        next_cycle();
        en_b = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) next_cycle();
            expect_b((i < 9) ? i : 9, (i >= 9), $sformatf("m9_e%0d", i));
        end
        next_cycle();
        rst_b = 1'b0;
        #1;
        check("m9_rst_data", 32'(data_b), 32'd0);
        check("m9_rst_max",  32'(max_b),  32'd0);
        rst_b = 1'b1; en_b = 1'b0;
        expect_b(0, 1'b0, "m9_after_rst");

`ifdef COUNTER_NR_LOAD_EN
        // Load 13 then count to saturation; load beats en.
        next_cycle();
        en_a = 1'b1; ld_a = 1'b1; lv_a = W'(13);
        expect_a(13, 1'b0, "ld13");
        next_cycle(); ld_a = 1'b0; expect_a(14, 1'b0, "ld14");
        next_cycle(); expect_a(15, 1'b1, "ld15");
        next_cycle(); expect_a(15, 1'b1, "ld15_hold");
        // Load above MAX_COUNT=9 is clamped.
        next_cycle();
        en_b = 1'b1; ld_b = 1'b1; lv_b = W'(15);
        expect_b(9, 1'b1, "ld_clamp");
        next_cycle(); ld_b = 1'b0; expect_b(9, 1'b1, "ld_clamp_hold");
`endif

        next_cycle();
        next_cycle();
        check("queue_drained", unsigned'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
